// File: rtl/calc_op_sequencer.sv
// calc_op_sequencer: shares one external WIDTH-bit add/sub unit between ADD, SUB
// and a shift-and-add MUL. Start/busy/done handshake, 2*WIDTH-bit result, a
// negative flag for SUB, and an error flag for the illegal opcode.
module calc_op_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [WIDTH-1:0]   a_in,
  input  logic [WIDTH-1:0]   b_in,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] result,
  output logic               neg,
  output logic               err,
  output logic [WIDTH-1:0]   au_a,
  output logic [WIDTH-1:0]   au_b,
  output logic               au_sub,
  input  logic [WIDTH-1:0]   au_sum,
  input  logic               au_cout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_MUL  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t             state_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic               sub_q;
  logic [WIDTH-1:0]   m_q;
  logic [2*WIDTH-1:0] p_q;
  logic [2*WIDTH-1:0] p_d;
  logic [CW-1:0]      cnt_q;
  logic               busy_q;
  logic               done_q;
  logic [2*WIDTH-1:0] result_q;
  logic               neg_q;
  logic               err_q;

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign neg    = neg_q;
  assign err    = err_q;

  // Unit operands: captured A/B in EXEC, P_hi + A in MUL, zero otherwise.
  always_comb begin
    au_a   = '0;
    au_b   = '0;
    au_sub = 1'b0;
    case (state_q)
      S_EXEC: begin
        au_a   = a_q;
        au_b   = b_q;
        au_sub = sub_q;
      end
      S_MUL: begin
        au_a = p_q[2*WIDTH-1:WIDTH];
        au_b = a_q;
      end
      default: ;
    endcase
  end

  // One shift-and-add step: add A into P_hi when the multiplier LSB is set, then shift right.
  always_comb begin
    if (m_q[0]) p_d = {au_cout, au_sum, p_q[WIDTH-1:1]};
    else        p_d = p_q >> 1;
  end

  // Controller FSM with registered handshake and result outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      sub_q    <= 1'b0;
      m_q      <= '0;
      p_q      <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      neg_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            a_q      <= a_in;
            b_q      <= b_in;
            sub_q    <= op[0];
            result_q <= '0;
            neg_q    <= 1'b0;
            err_q    <= 1'b0;
            busy_q   <= 1'b1;
            case (op)
              2'b00, 2'b01: state_q <= S_EXEC;
              2'b10: begin
                state_q <= S_MUL;
                cnt_q   <= '0;
                p_q     <= '0;
                m_q     <= b_in;
              end
              default: begin
                state_q <= S_DONE;
                err_q   <= 1'b1;
                done_q  <= 1'b1;
              end
            endcase
          end
        end
        S_EXEC: begin
          if (sub_q) begin
            result_q <= {{WIDTH{1'b0}}, au_sum};
            neg_q    <= ~au_cout;
          end else begin
            result_q <= {{(WIDTH-1){1'b0}}, au_cout, au_sum};
            neg_q    <= 1'b0;
          end
          state_q <= S_DONE;
          done_q  <= 1'b1;
        end
        S_MUL: begin
          p_q   <= p_d;
          m_q   <= m_q >> 1;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(WIDTH - 1)) begin
            result_q <= p_d;
            state_q  <= S_DONE;
            done_q   <= 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_calc_op_sequencer.sv
// tb_calc_op_sequencer: table-driven vectors plus hand-written corner sequences;
// expected results are queued at start and compared when done pulses.
module tb_calc_op_sequencer;

  localparam int W = 16;

  logic           clk;
  logic           reset_n;
  logic           start;
  logic [1:0]     op;
  logic [W-1:0]   a_in, b_in;
  logic           busy, done, neg, err;
  logic [2*W-1:0] result;
  logic [W-1:0]   au_a, au_b, au_sum;
  logic           au_sub, au_cout;

  calc_op_sequencer #(.WIDTH(W)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op(op),
    .a_in(a_in), .b_in(b_in), .busy(busy), .done(done),
    .result(result), .neg(neg), .err(err),
    .au_a(au_a), .au_b(au_b), .au_sub(au_sub),
    .au_sum(au_sum), .au_cout(au_cout)
  );

  // External ripple add/sub unit model.
  logic [W:0] au_full;
  assign au_full = au_sub ? ({1'b0, au_a} + {1'b0, ~au_b} + 17'd1)
                          : ({1'b0, au_a} + {1'b0, au_b});
  assign au_sum  = au_full[W-1:0];
  assign au_cout = au_full[W];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;
  int n_done = 0;

  typedef struct {
    logic [1:0]     op;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] res;
    logic           neg;
    logic           err;
    int             lat;
  } vec_t;

  typedef struct {
    logic [2*W-1:0] res;
    logic           neg;
    logic           err;
    int             lat;
    int             s;
    string          tag;
  } exp_t;

  exp_t sb_q[$];

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Scoreboard monitor: one line per completed transaction.
  always @(negedge clk) begin
    if (reset_n && done) begin
      n_done++;
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_done: got done=1 expected no pending request (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check({e.tag, "_result"}, result, e.res);
        check({e.tag, "_neg"}, 32'(neg), 32'(e.neg));
        check({e.tag, "_err"}, 32'(err), 32'(e.err));
        check({e.tag, "_latency"}, 32'(cyc - e.s), 32'(e.lat));
        $display("txn %s: result=0x%08h neg=%0d err=%0d latency=%0d", e.tag, result, neg, err, cyc - e.s);
      end
    end
  end

  task automatic drive_start(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic [2*W-1:0] res, input logic n, input logic e,
                             input int lat, input string tag);
    exp_t x;
    int k;
    k = 0;
    @(negedge clk);
    while (busy && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (busy) check({tag, "_idle_timeout"}, 32'(busy), 32'd0);
    op = o; a_in = a; b_in = b; start = 1'b1;
    x.res = res; x.neg = n; x.err = e; x.lat = lat; x.s = cyc; x.tag = tag;
    sb_q.push_back(x);
    @(negedge clk);
    start = 1'b0;
    a_in = W'($urandom);
    b_in = W'($urandom);
  endtask

  task automatic wait_drain(input string tag);
    for (int k = 0; k < 40 && sb_q.size() != 0; k++) @(negedge clk);
    if (sb_q.size() != 0) begin
      check({tag, "_done_timeout"}, 32'(sb_q.size()), 32'd0);
      sb_q.delete();
    end
    @(negedge clk);
    check({tag, "_done_pulse_end"}, 32'(done), 32'd0);
    check({tag, "_au_idle"}, {15'd0, au_sub, au_a ^ au_b}, 32'd0);
  endtask

  vec_t vecs[10];

  initial begin
    int s;
    int d0;
    logic [W-1:0] ra, rb;

    // Vector table.
    vecs[0] = '{2'b00, 16'd1234, 16'd4321, 32'd5555, 1'b0, 1'b0, 2};
    vecs[1] = '{2'b00, 16'hFFFF, 16'h0001, 32'h0001_0000, 1'b0, 1'b0, 2};
    vecs[2] = '{2'b01, 16'd5, 16'd9, 32'h0000_FFFC, 1'b1, 1'b0, 2};
    vecs[3] = '{2'b01, 16'd9, 16'd5, 32'd4, 1'b0, 1'b0, 2};
    vecs[4] = '{2'b10, 16'hFFFF, 16'hFFFF, 32'hFFFE_0001, 1'b0, 1'b0, 17};
    vecs[5] = '{2'b10, 16'h0000, 16'h1234, 32'd0, 1'b0, 1'b0, 17};
    vecs[6] = '{2'b11, 16'd7, 16'd7, 32'd0, 1'b0, 1'b1, 1};
    vecs[7] = '{2'b00, 16'd10, 16'd20, 32'd30, 1'b0, 1'b0, 2};
    ra = W'($urandom); rb = W'($urandom);
    vecs[8] = '{2'b10, ra, rb, 32'(ra) * 32'(rb), 1'b0, 1'b0, 17};
    ra = W'($urandom); rb = W'($urandom);
    vecs[9] = '{2'b01, ra, rb, {16'd0, ra - rb}, (ra < rb), 1'b0, 2};

    reset_n = 1'b0; start = 1'b0; op = 2'b00; a_in = '0; b_in = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_result", result, 32'd0);
    check("reset_flags", {30'd0, neg, err}, 32'd0);
    check("reset_au", {15'd0, au_sub, au_a | au_b}, 32'd0);
    reset_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      drive_start(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].neg,
                  vecs[i].err, vecs[i].lat, $sformatf("vec%0d", i));
      wait_drain($sformatf("vec%0d", i));
    end

    // MUL 3*7 with start pulses at cycles 5 and 17 that must be dropped.
    d0 = n_done;
    @(negedge clk);
    s = cyc;
    op = 2'b10; a_in = 16'd3; b_in = 16'd7; start = 1'b1;
    sb_q.push_back('{32'd21, 1'b0, 1'b0, 17, s, "mul_busy_start"});
    @(negedge clk);
    start = 1'b0;
    while (cyc < s + 5) @(negedge clk);
    op = 2'b00; a_in = 16'd1; b_in = 16'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (cyc < s + 17) @(negedge clk);
    op = 2'b00; a_in = 16'd1; b_in = 16'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("mul_busy_pending", 32'(sb_q.size()), 32'd0);
    sb_q.delete();
    check("mul_busy_done_count", 32'(n_done - d0), 32'd1);
    check("mul_busy_result_held", result, 32'd21);
    check("mul_busy_idle", 32'(busy), 32'd0);
    $display("txn mul_busy_start: done_pulses=%0d result=0x%08h", n_done - d0, result);

    // MUL 100*200 aborted by reset at cycle 8, then ADD 2+2.
    @(negedge clk);
    s = cyc;
    op = 2'b10; a_in = 16'd100; b_in = 16'd200; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (cyc < s + 8) @(negedge clk);
    check("abort_busy_before", 32'(busy), 32'd1);
    reset_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_result", result, 32'd0);
    check("abort_au", {15'd0, au_sub, au_a | au_b}, 32'd0);
    $display("txn mul_abort: busy=%0d done=%0d result=0x%08h", busy, done, result);
    @(negedge clk);
    reset_n = 1'b1;
    drive_start(2'b00, 16'd2, 16'd2, 32'd4, 1'b0, 1'b0, 2, "add_after_reset");
    wait_drain("add_after_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
